// File: rtl/spi_frame_master.sv
// SPI mode-0 master for two-byte expander frames: the command byte and the data byte
// each get their own ss window, and the miso byte seen during the data window is returned.
module spi_frame_master #(
  parameter int CLK_DIV    = 10,
  parameter int GAP_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic [7:0] data_byte,
  output logic       rsp_valid,
  output logic [7:0] rsp_byte,
  output logic       busy,
  output logic       ss,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam int MAX_CNT = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    edge_q, edge_d;
  logic          byte_idx_q, byte_idx_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    rsp_byte_q, rsp_byte_d;
  logic          ss_q, ss_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          busy_q, busy_d;
  logic          accept;

  assign cmd_ready = (state_q == IDLE) && !rsp_valid_q;
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_byte  = rsp_byte_q;
  assign busy      = busy_q;
  assign ss        = ss_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    edge_d      = edge_q;
    byte_idx_d  = byte_idx_q;
    tx_d        = tx_q;
    data_d      = data_q;
    rx_d        = rx_q;
    rsp_byte_d  = rsp_byte_q;
    ss_d        = ss_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = SETUP;
          cnt_d      = '0;
          byte_idx_d = 1'b0;
          tx_d       = cmd_byte;
          data_d     = data_byte;
          ss_d       = 1'b1;
          mosi_d     = cmd_byte[7];
          busy_d     = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          edge_d  = 4'd0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHIFT: begin
        // edge_q counts sclk toggles; odd values are falling edges
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          sclk_d = !sclk_q;
          edge_d = edge_q + 4'd1;
          if (!sclk_q) begin
            rx_d = {rx_q[6:0], miso};
          end else if (edge_q == 4'd15) begin
            state_d = HOLD;
          end else begin
            tx_d   = {tx_q[6:0], tx_q[7]};
            mosi_d = tx_q[6];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          ss_d   = 1'b0;
          mosi_d = 1'b0;
          if (byte_idx_q) begin
            state_d = DONE;
          end else begin
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d    = SETUP;
          cnt_d      = '0;
          byte_idx_d = 1'b1;
          tx_d       = data_q;
          ss_d       = 1'b1;
          mosi_d     = data_q[7];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        rsp_valid_d = 1'b1;
        rsp_byte_d  = rx_q;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      edge_q      <= 4'd0;
      byte_idx_q  <= 1'b0;
      tx_q        <= 8'h00;
      data_q      <= 8'h00;
      rx_q        <= 8'h00;
      rsp_byte_q  <= 8'h00;
      ss_q        <= 1'b0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      edge_q      <= edge_d;
      byte_idx_q  <= byte_idx_d;
      tx_q        <= tx_d;
      data_q      <= data_d;
      rx_q        <= rx_d;
      rsp_byte_q  <= rsp_byte_d;
      ss_q        <= ss_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: two instances (CLK_DIV=2/GAP=4 and CLK_DIV=1/GAP=1) driven
// with directed and random frames, every output compared each cycle against a timing model.
module tb_spi_frame_master;

  localparam int D0 = 2;
  localparam int G0 = 4;
  localparam int D1 = 1;
  localparam int G1 = 1;

  logic       clk = 1'b0;
  logic       rst_n_w     [2];
  logic       cmd_valid_w [2];
  logic       cmd_ready_w [2];
  logic [7:0] cmd_w       [2];
  logic [7:0] data_w      [2];
  logic       rsp_valid_w [2];
  logic [7:0] rsp_w       [2];
  logic       busy_w      [2];
  logic       ss_w        [2];
  logic       sclk_w      [2];
  logic       mosi_w      [2];
  logic       miso_w      [2];

  logic [7:0] mpat    [2][2];
  logic [7:0] rsp_exp [2];
  int         n_checks = 0;
  int         n_errors = 0;

  int         win_m  [2];
  int         bitn   [2];
  logic       ss_p   [2] = '{1'b0, 1'b0};
  logic       sclk_p [2] = '{1'b0, 1'b0};
  logic [7:0] cur    [2];

  initial forever #5 clk = ~clk;

  spi_frame_master #(.CLK_DIV(D0), .GAP_CYCLES(G0)) dut0 (
    .clk(clk), .rst_n(rst_n_w[0]), .cmd_valid(cmd_valid_w[0]), .cmd_ready(cmd_ready_w[0]),
    .cmd_byte(cmd_w[0]), .data_byte(data_w[0]), .rsp_valid(rsp_valid_w[0]), .rsp_byte(rsp_w[0]),
    .busy(busy_w[0]), .ss(ss_w[0]), .sclk(sclk_w[0]), .mosi(mosi_w[0]), .miso(miso_w[0])
  );

  spi_frame_master #(.CLK_DIV(D1), .GAP_CYCLES(G1)) dut1 (
    .clk(clk), .rst_n(rst_n_w[1]), .cmd_valid(cmd_valid_w[1]), .cmd_ready(cmd_ready_w[1]),
    .cmd_byte(cmd_w[1]), .data_byte(data_w[1]), .rsp_valid(rsp_valid_w[1]), .rsp_byte(rsp_w[1]),
    .busy(busy_w[1]), .ss(ss_w[1]), .sclk(sclk_w[1]), .mosi(mosi_w[1]), .miso(miso_w[1])
  );

  // Expander-side miso model: first bit on ss rise, next bit on each sclk fall.
  always @(posedge clk) begin
    #1;
    for (int u = 0; u < 2; u++) begin
      if (busy_w[u] !== 1'b1) win_m[u] = 0;
      if (ss_w[u] === 1'b1 && ss_p[u] === 1'b0) begin
        cur[u]    = mpat[u][win_m[u]];
        bitn[u]   = 7;
        miso_w[u] = cur[u][7];
        win_m[u]  = 1;
      end else if (ss_w[u] === 1'b1 && sclk_p[u] === 1'b1 && sclk_w[u] === 1'b0 && bitn[u] > 0) begin
        bitn[u]   = bitn[u] - 1;
        miso_w[u] = cur[u][bitn[u]];
      end
      ss_p[u]   = ss_w[u];
      sclk_p[u] = sclk_w[u];
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input int u, input string tag);
    check($sformatf("%s_ss u%0d", tag, u),        8'(ss_w[u]),        8'd0);
    check($sformatf("%s_sclk u%0d", tag, u),      8'(sclk_w[u]),      8'd0);
    check($sformatf("%s_mosi u%0d", tag, u),      8'(mosi_w[u]),      8'd0);
    check($sformatf("%s_busy u%0d", tag, u),      8'(busy_w[u]),      8'd0);
    check($sformatf("%s_rsp_valid u%0d", tag, u), 8'(rsp_valid_w[u]), 8'd0);
    check($sformatf("%s_rsp_byte u%0d", tag, u),  rsp_w[u],           8'h00);
    check($sformatf("%s_ready u%0d", tag, u),     8'(cmd_ready_w[u]), 8'd1);
  endtask

  // Runs one frame starting at a negedge; abort_k >= 0 pulls reset after that cycle.
  task automatic run_frame(input int u, input logic [7:0] c, input logic [7:0] d,
                           input logic [7:0] mc, input logic [7:0] md,
                           input bit hold, input int abort_k);
    int dv, gv, last, kp, p, n;
    logic e_ss, e_sclk, e_mosi;
    logic [7:0] b;
    dv   = (u == 0) ? D0 : D1;
    gv   = (u == 0) ? G0 : G1;
    last = 36 * dv + gv + 1;
    mpat[u][0] = mc;
    mpat[u][1] = md;
    check($sformatf("ready_pre u%0d", u), 8'(cmd_ready_w[u]), 8'd1);
    cmd_valid_w[u] = 1'b1;
    cmd_w[u]       = c;
    data_w[u]      = d;
    @(posedge clk);
    for (int k = 0; k <= last + 1; k++) begin
      @(negedge clk);
      if (hold) begin
        cmd_w[u]  = 8'($urandom);
        data_w[u] = 8'($urandom);
      end else begin
        cmd_valid_w[u] = 1'b0;
      end
      if (k < 18 * dv) begin
        kp = k; b = c; e_ss = 1'b1;
      end else if (k >= 18 * dv + gv && k < 36 * dv + gv) begin
        kp = k - 18 * dv - gv; b = d; e_ss = 1'b1;
      end else begin
        kp = 0; b = 8'h00; e_ss = 1'b0;
      end
      p      = kp / dv;
      e_sclk = e_ss && p >= 2 && p <= 16 && (p % 2 == 0);
      n      = (p >= 3) ? (((p - 1) / 2 > 7) ? 7 : (p - 1) / 2) : 0;
      e_mosi = e_ss && b[7 - n];
      if (k == last) rsp_exp[u] = md;
      check($sformatf("ss u%0d k%0d", u, k),        8'(ss_w[u]),        8'(e_ss));
      check($sformatf("sclk u%0d k%0d", u, k),      8'(sclk_w[u]),      8'(e_sclk));
      check($sformatf("mosi u%0d k%0d", u, k),      8'(mosi_w[u]),      8'(e_mosi));
      check($sformatf("busy u%0d k%0d", u, k),      8'(busy_w[u]),      8'(k <= last));
      check($sformatf("ready u%0d k%0d", u, k),     8'(cmd_ready_w[u]), 8'(k > last));
      check($sformatf("rsp_valid u%0d k%0d", u, k), 8'(rsp_valid_w[u]), 8'(k == last));
      check($sformatf("rsp_byte u%0d k%0d", u, k),  rsp_w[u],           rsp_exp[u]);
      if (k == abort_k) begin
        rst_n_w[u] = 1'b0;
        @(negedge clk);
        rst_n_w[u]     = 1'b1;
        cmd_valid_w[u] = 1'b0;
        rsp_exp[u]     = 8'h00;
        check_idle(u, "abort");
        return;
      end
    end
  endtask

  initial begin
    int u, ab, lastk;
    bit hold;
    for (int i = 0; i < 2; i++) begin
      rst_n_w[i]     = 1'b0;
      cmd_valid_w[i] = 1'b1;
      cmd_w[i]       = 8'hFF;
      data_w[i]      = 8'hFF;
      rsp_exp[i]     = 8'h00;
      mpat[i][0]     = 8'h00;
      mpat[i][1]     = 8'h00;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_idle(0, "reset");
      check_idle(1, "reset");
    end
    for (int i = 0; i < 2; i++) begin
      rst_n_w[i]     = 1'b1;
      cmd_valid_w[i] = 1'b0;
    end
    @(negedge clk);
    check_idle(0, "post_reset");
    check_idle(1, "post_reset");

    run_frame(0, 8'h9B, 8'hAA, 8'h3C, 8'hC3, 1'b0, -1);
    run_frame(0, 8'h12, 8'h34, 8'hFF, 8'h5A, 1'b0, -1);
    run_frame(0, 8'hA5, 8'h5A, 8'h81, 8'h7E, 1'b1, -1);
    run_frame(0, 8'h3C, 8'hE1, 8'h00, 8'h96, 1'b0, -1);
    run_frame(0, 8'hC4, 8'h2D, 8'h55, 8'hB7, 1'b0, 18 * D0 + G0 + 7 * D0);
    run_frame(0, 8'h80, 8'h00, 8'hF0, 8'h0F, 1'b0, -1);
    run_frame(1, 8'h80, 8'h08, 8'hFF, 8'hA5, 1'b0, -1);

    u = 0;
    for (int i = 0; i < 24; i++) begin
      hold  = (i < 23) && ($urandom_range(0, 3) == 0);
      lastk = (u == 0) ? 36 * D0 + G0 + 1 : 36 * D1 + G1 + 1;
      ab    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, lastk)) : -1;
      run_frame(u, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), hold, ab);
      if (!hold) u = int'($urandom_range(0, 1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_frame_master.md
Name: spi_frame_master

Overview:
SPI master that serialises two-byte command frames (command byte, then data byte) for the SPI port of the GPIO expander. It sits upstream of the expander, between a local command source (controller FSM or test harness) and the expander's ss/sclk/mosi/miso pins. Each byte is sent in its own ss-active window. The byte shifted back on miso during the data byte is returned as the response.

Parameters:
CLK_DIV, 10, system-clock cycles per sclk half-period; legal range ≥1.
GAP_CYCLES, 20, ss-inactive cycles between the command-byte window and the data-byte window; legal range ≥1.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  synchronous reset, active-low.
cmd_valid  input  1  frame request.
cmd_ready  output  1  high when idle and able to accept a frame.
cmd_byte  input  8  first byte of the frame, sent MSB first.
data_byte  input  8  second byte of the frame, sent MSB first.
rsp_valid  output  1  one-cycle pulse when the frame completes.
rsp_byte  output  8  miso byte captured during the data-byte window.
busy  output  1  high from frame accept through the rsp_valid cycle.
ss  output  1  slave select, active-high.
sclk  output  1  SPI clock; idles low (mode 0).
mosi  output  1  serial data to the expander.
miso  input  1  serial data from the expander.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State returns to IDLE.
  - Outputs: ss=0, sclk=0, mosi=0, rsp_valid=0, rsp_byte=0x00, busy=0, cmd_ready=1.
  - Internal counters and shift registers clear.
  - A reset mid-frame aborts the frame immediately. No rsp_valid is produced for the aborted frame.
- Handshake:
  - A frame is accepted on a clk edge where cmd_valid && cmd_ready.
  - cmd_byte and data_byte are latched on that edge; later changes to the inputs have no effect.
  - cmd_ready = (state==IDLE) && !rsp_valid, so a new frame cannot be accepted in the rsp_valid cycle.
- States: IDLE, SETUP, SHIFT, HOLD, GAP, DONE.
  - IDLE → SETUP on accept. The byte index is set to 0 (command byte).
  - SETUP: ss=1 and mosi=bit7 of the current byte, both from the first cycle. Stays CLK_DIV cycles, then → SHIFT.
  - SHIFT: sclk toggles every CLK_DIV cycles, giving 8 rising and 8 falling edges.
    - On each rising edge, miso is sampled into the receive shift register (MSB first).
    - On each of the first 7 falling edges, mosi advances to the next lower bit.
    - After the 8th falling edge → HOLD, with sclk=0 and mosi holding bit0.
  - HOLD: ss stays 1 for CLK_DIV cycles. Then ss=0.
    - Byte index 0 → GAP.
    - Byte index 1 → DONE.
  - GAP: ss=0, sclk=0, for GAP_CYCLES cycles. Then byte index becomes 1 → SETUP.
  - DONE: lasts one cycle. rsp_valid=1 and rsp_byte = receive register from the data-byte window; then → IDLE.
- Timing:
  - ss is high for exactly 18·CLK_DIV cycles per byte.
  - Accept edge to rsp_valid is 36·CLK_DIV + GAP_CYCLES + 1 cycles.
- rsp_byte holds its value until the next frame's DONE or reset.
- miso bits sampled during the command-byte window are discarded.
- sclk never toggles while ss=0. ss never changes while sclk=1.
- mosi is 0 whenever ss=0.
- All outputs are registered; there are no combinational paths from input to output except cmd_ready, which derives from state only.

Test Plan:
1. Reset values: hold rst_n=0 for 3 cycles with cmd_valid=1 → ss=0, sclk=0, mosi=0, busy=0, rsp_valid=0, rsp_byte=0x00, cmd_ready=1, and no transfer starts.
2. Basic frame (CLK_DIV=2, GAP_CYCLES=4): cmd_byte=0x9B, data_byte=0xAA →
   - mosi sampled at sclk rising edges reads 1,0,0,1,1,0,1,1 then 1,0,1,0,1,0,1,0.
   - Two ss windows of 36 cycles each, separated by 4 low cycles.
   - rsp_valid pulses exactly 77 cycles after accept.
3. Response capture: a miso model drives 0xFF during the command window and 0x5A during the data window, MSB first, changing on sclk falling edges → rsp_byte=0x5A. Bits captured in the command window do not appear in rsp_byte.
4. Backpressure:
   - cmd_valid held high with new bytes while busy → cmd_ready=0, and the in-flight bytes are unchanged.
   - The second frame is accepted on the first cycle after the rsp_valid cycle.
5. Reset mid-frame: assert rst_n=0 during the 4th bit of the data byte →
   - Next cycle: ss=0, sclk=0, no rsp_valid, rsp_byte=0x00.
   - A following frame 0x80/0x00 completes normally.
6. Minimum divider (CLK_DIV=1, GAP_CYCLES=1): frame 0x80/0x08 → sclk period is 2 cycles, ss high for 18 cycles per byte, and rsp_valid arrives 38 cycles after accept.
